tdm_demux_1_to_4: RTL and testbench
===================================

Name: tdm_demux_1_to_4

Overview:
Time-division demultiplexer that splits one serial sample stream into four parallel channels. It is the receive-side counterpart of the 4-to-1 channel mux used on the TDM link. Each valid sample is steered to Data0..Data3 by an internal 2-bit channel counter, which is aligned to a frame marker. The block locks onto frames, holds the latest sample per channel, pulses per-channel valids, and flags framing errors.

Parameters:
WIDTH, 8, bit width of each sample and of each channel output register.

Ports:
i_Clk  input  1  system clock, all logic rising-edge.
i_Rst_L  input  1  synchronous active-low reset, sampled on rising edge of i_Clk.
i_Data  input  WIDTH  incoming TDM sample.
i_DV  input  1  i_Data valid this cycle; samples are not required on consecutive cycles.
i_Frame  input  1  qualified by i_DV; marks the sample as channel 0.
o_Data0..o_Data3  output  WIDTH each  last sample captured for channel 0..3, held until overwritten.
o_DV0..o_DV3  output  1 each  one-cycle pulse when the matching o_DataN updates.
o_Frame_DV  output  1  one-cycle pulse when channel 3 completes an aligned frame.
o_Sel1, o_Sel0  output  1 each  channel index the next valid sample will be written to (Sel1 = MSB).
o_Locked  output  1  high while in LOCKED state.
o_Sync_Err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (i_Rst_L=0 at a clock edge):
  - All o_DataN = 0; all pulses = 0; o_Sel1/o_Sel0 = 00; o_Locked = 0.
  - State = HUNT.
  - Reset mid-frame discards any partial frame. There is no flush.
- Accepted sample: a cycle with i_DV=1. Cycles with i_DV=0 change nothing, and all pulse outputs are 0.
- Latency: a sample accepted at edge N appears on o_DataN, with its o_DVN pulse, after edge N (registered, 1 cycle).
- HUNT state:
  - Accepted sample with i_Frame=0: dropped. No output. No error.
  - Accepted sample with i_Frame=1: written to o_Data0, o_DV0 pulses, counter becomes 1, state becomes LOCKED.
- LOCKED state, counter C (0..3):
  - i_Frame=1 and C=0: normal. Write ch0, C becomes 1.
  - i_Frame=0 and C in 1..3: normal. Write chC, pulse o_DVC, C becomes C+1 mod 4. When C=3, also pulse o_Frame_DV in the same cycle as o_DV3.
  - i_Frame=1 and C≠0 (early frame): pulse o_Sync_Err and resync. The sample is written to ch0, o_DV0 pulses, C becomes 1, and the state stays LOCKED. No o_Frame_DV for the truncated frame.
  - i_Frame=0 and C=0 (missing frame): pulse o_Sync_Err and drop the sample. No DV. C becomes 0, state becomes HUNT, o_Locked becomes 0.
- i_Frame when i_DV=0: ignored.
- Counter wrap: 3 to 0 only through a normal ch3 write. The counter never advances in HUNT.
- o_Sel1/o_Sel0 reflect C registered (00 in HUNT). They are driven so that an external 4-to-1 mux fed with o_Data0..3 and o_Sel1/o_Sel0 reproduces the channel order.
- At most one o_DVN is high in any cycle. o_Sync_Err and o_DV0 may be high together (early-frame case).
- No backpressure: every accepted sample is consumed in one cycle, and the block sustains one sample per clock.

Test Plan:
- Reset then lock: hold i_Rst_L=0 for 3 cycles, release. Send i_DV=1 with i_Data=0x11(F=1), 0x22, 0x33, 0x44 on consecutive cycles. Required: o_Data0..3=0x11,0x22,0x33,0x44. o_DV0..3 pulse on successive cycles, each one cycle after its input. o_Frame_DV coincides with o_DV3. o_Locked=1. o_Sync_Err never high.
- HUNT discard: after reset, send 0xAA, 0xBB (F=0), then 0x10 (F=1). Required: 0xAA and 0xBB produce no DV and no error. o_Data0=0x10 and o_Locked rises after the third sample.
- Early frame: locked, send ch0=0x01(F=1), ch1=0x02, then 0x05 with F=1. Required: o_Sync_Err pulses together with o_DV0, o_Data0=0x05, o_Sel=01, no o_Frame_DV, o_Data2 unchanged.
- Missing frame: after a complete frame, send 0x77 with F=0. Required: o_Sync_Err pulses, no DV, o_Data0 retains its old value, o_Locked=0, o_Sel=00. A following F=1 sample relocks.
- Gapped input: frame samples separated by 0–3 idle cycles of i_DV=0, with i_Frame toggling randomly during idle cycles. Required: same outputs as the back-to-back case, no errors, pulses only on valid cycles.
- Reset mid-frame: locked after ch1, assert i_Rst_L=0 for 1 cycle. Required: all outputs 0 on the next cycle, HUNT state. A subsequent F=0 sample is dropped without error.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// rtl/tdm_demux_1_to_4.sv - frame-aligned 1-to-4 TDM demultiplexer with lock tracking
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_DV,
    input  logic             i_Frame,
    output logic [WIDTH-1:0] o_Data0,
    output logic [WIDTH-1:0] o_Data1,
    output logic [WIDTH-1:0] o_Data2,
    output logic [WIDTH-1:0] o_Data3,
    output logic             o_DV0,
    output logic             o_DV1,
    output logic             o_DV2,
    output logic             o_DV3,
    output logic             o_Frame_DV,
    output logic             o_Sel1,
    output logic             o_Sel0,
    output logic             o_Locked,
    output logic             o_Sync_Err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       dv_q, dv_d;
    logic             frame_dv_q, frame_dv_d;
    logic             sync_err_q, sync_err_d;
    logic             wr_en;
    logic [1:0]       wr_ch;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        wr_ch      = 2'd0;
        frame_dv_d = 1'b0;
        sync_err_d = 1'b0;
        if (i_DV) begin
            case (state_q)
                HUNT: begin
                    if (i_Frame) begin
                        wr_en   = 1'b1;
                        cnt_d   = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (i_Frame) begin
                        // A frame marker always realigns to ch0; it is an error only if early.
                        wr_en      = 1'b1;
                        cnt_d      = 2'd1;
                        sync_err_d = (cnt_q != 2'd0);
                    end else if (cnt_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        cnt_d      = 2'd0;
                        state_d    = HUNT;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ch      = cnt_q;
                        cnt_d      = cnt_q + 2'd1;
                        frame_dv_d = (cnt_q == 2'd3);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        dv_d = wr_en ? (4'b0001 << wr_ch) : 4'b0000;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= HUNT;
            cnt_q      <= 2'd0;
            dv_q       <= 4'b0000;
            frame_dv_q <= 1'b0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dv_q       <= dv_d;
            frame_dv_q <= frame_dv_d;
            sync_err_q <= sync_err_d;
            if (wr_en) begin
                data_q[wr_ch] <= i_Data;
            end
        end
    end

    assign o_Data0    = data_q[0];
    assign o_Data1    = data_q[1];
    assign o_Data2    = data_q[2];
    assign o_Data3    = data_q[3];
    assign o_DV0      = dv_q[0];
    assign o_DV1      = dv_q[1];
    assign o_DV2      = dv_q[2];
    assign o_DV3      = dv_q[3];
    assign o_Frame_DV = frame_dv_q;
    assign o_Sel1     = cnt_q[1];
    assign o_Sel0     = cnt_q[0];
    assign o_Locked   = (state_q == LOCKED);
    assign o_Sync_Err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// tb/tb_tdm_demux_1_to_4.sv - scoreboard bench for tdm_demux_1_to_4
module tb_tdm_demux_1_to_4;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_dv = 1'b0;
    logic       i_frame = 1'b0;
    logic [7:0] o_data0, o_data1, o_data2, o_data3;
    logic       o_dv0, o_dv1, o_dv2, o_dv3;
    logic       o_frame_dv, o_sel1, o_sel0, o_locked, o_sync_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0][7:0] data;
        logic [3:0]      dv;
        logic            fdv;
        logic [1:0]      sel;
        logic            locked;
        logic            se;
    } exp_t;

    exp_t       sb[$];
    logic       m_locked = 1'b0;
    logic [1:0] m_cnt = 2'd0;
    logic [3:0][7:0] m_data = '0;

    tdm_demux_1_to_4 #(.WIDTH(8)) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Data(i_data), .i_DV(i_dv), .i_Frame(i_frame),
        .o_Data0(o_data0), .o_Data1(o_data1), .o_Data2(o_data2), .o_Data3(o_data3),
        .o_DV0(o_dv0), .o_DV1(o_dv1), .o_DV2(o_dv2), .o_DV3(o_dv3),
        .o_Frame_DV(o_frame_dv), .o_Sel1(o_sel1), .o_Sel0(o_sel0),
        .o_Locked(o_locked), .o_Sync_Err(o_sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic rst, input logic dv, input logic fr, input logic [7:0] d);
        exp_t e;
        e = '0;
        if (!rst) begin
            m_locked = 1'b0;
            m_cnt    = 2'd0;
            m_data   = '0;
        end else if (dv) begin
            if (fr) begin
                e.se      = m_locked && (m_cnt != 2'd0);
                m_data[0] = d;
                e.dv[0]   = 1'b1;
                m_cnt     = 2'd1;
                m_locked  = 1'b1;
            end else if (m_locked && m_cnt == 2'd0) begin
                e.se     = 1'b1;
                m_locked = 1'b0;
            end else if (m_locked) begin
                m_data[m_cnt] = d;
                e.dv[m_cnt]   = 1'b1;
                e.fdv         = (m_cnt == 2'd3);
                m_cnt         = m_cnt + 2'd1;
            end
        end
        e.data   = m_data;
        e.sel    = m_cnt;
        e.locked = m_locked;
        return e;
    endfunction

    task automatic step(input logic rst, input logic dv, input logic fr, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst_l   = rst;
        i_dv    = dv;
        i_frame = fr;
        i_data  = d;
        sb.push_back(model(rst, dv, fr, d));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("data0", {24'd0, o_data0}, {24'd0, e.data[0]});
        check("data1", {24'd0, o_data1}, {24'd0, e.data[1]});
        check("data2", {24'd0, o_data2}, {24'd0, e.data[2]});
        check("data3", {24'd0, o_data3}, {24'd0, e.data[3]});
        check("dv", {28'd0, o_dv3, o_dv2, o_dv1, o_dv0}, {28'd0, e.dv});
        check("frame_dv", {31'd0, o_frame_dv}, {31'd0, e.fdv});
        check("sel", {30'd0, o_sel1, o_sel0}, {30'd0, e.sel});
        check("locked", {31'd0, o_locked}, {31'd0, e.locked});
        check("sync_err", {31'd0, o_sync_err}, {31'd0, e.se});
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    initial begin
        // reset then lock
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_locked", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b1, 1'b0, 8'h44);
        check("lock_fdv", {31'd0, o_frame_dv}, 32'd1);
        check("lock_d0", {24'd0, o_data0}, 32'h11);
        check("lock_d3", {24'd0, o_data3}, 32'h44);
        check("lock_locked", {31'd0, o_locked}, 32'd1);

        // HUNT discard
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 8'hBB);
        check("hunt_locked", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h10);
        check("hunt_d0", {24'd0, o_data0}, 32'h10);
        check("hunt_locked2", {31'd0, o_locked}, 32'd1);

        // early frame
        step(1'b1, 1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b1, 1'b1, 8'h05);
        check("early_err", {31'd0, o_sync_err}, 32'd1);
        check("early_dv0", {31'd0, o_dv0}, 32'd1);
        check("early_d0", {24'd0, o_data0}, 32'h05);
        check("early_sel", {30'd0, o_sel1, o_sel0}, 32'd1);

        // missing frame
        step(1'b1, 1'b1, 1'b0, 8'h06);
        step(1'b1, 1'b1, 1'b0, 8'h07);
        step(1'b1, 1'b1, 1'b0, 8'h08);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        check("miss_err", {31'd0, o_sync_err}, 32'd1);
        check("miss_d0", {24'd0, o_data0}, 32'h05);
        check("miss_locked", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h99);
        check("relock", {31'd0, o_locked}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'h9A);
        step(1'b1, 1'b1, 1'b0, 8'h9B);
        step(1'b1, 1'b1, 1'b0, 8'h9C);

        // gapped input
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 4; c++) begin
                idle_gap();
                step(1'b1, 1'b1, (c == 0), 8'(f * 16 + c + 1));
            end
        end
        check("gap_d3", {24'd0, o_data3}, 32'h54);

        // reset mid-frame
        step(1'b1, 1'b1, 1'b1, 8'hC0);
        step(1'b1, 1'b1, 1'b0, 8'hC1);
        step(1'b0, 1'b1, 1'b0, 8'hC2);
        check("mrst_d1", {24'd0, o_data1}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'hC3);
        check("mrst_err", {31'd0, o_sync_err}, 32'd0);
        check("mrst_locked", {31'd0, o_locked}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
